// File: rtl/rf_pkg.sv
// Shared types and defaults for the register file writeback arbiter.
// Imported by rr_arb2 and rf_wb_arbiter.
package rf_pkg;

    localparam int DATA_W_DFLT = 32;
    localparam int ADDR_W_DFLT = 5;

    // Architectural zero register; writes to it are accepted but dropped.
    localparam int REG_ZERO = 0;

    typedef enum logic {
        GNT_ALU = 1'b0,
        GNT_LD  = 1'b1
    } grant_e;

endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter (ALU vs load writeback).
// Grant is combinational; last_grant is the registered priority pointer.
module rr_arb2
    import rf_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req_alu,
    input  logic req_ld,
    output logic gnt_alu,
    output logic gnt_ld
);

    grant_e last_grant;

    // Grant from valids and pointer only; nothing granted while in reset.
    always_comb begin
        gnt_alu = 1'b0;
        gnt_ld  = 1'b0;
        if (reset_n) begin
            unique case ({req_alu, req_ld})
                2'b10: gnt_alu = 1'b1;
                2'b01: gnt_ld  = 1'b1;
                2'b11: begin
                    if (last_grant == GNT_LD) begin
                        gnt_alu = 1'b1;
                    end else begin
                        gnt_ld = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pointer follows every transfer; reset favours the ALU next.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= GNT_LD;
        end else if (gnt_alu) begin
            last_grant <= GNT_ALU;
        end else if (gnt_ld) begin
            last_grant <= GNT_LD;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register file write-port arbiter with a one-entry output stage.
// Define RF_WB_FWD_EN to build the staged-write forwarding comparators.
module rf_wb_arbiter
    import rf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              rg_wrt_en,
    output logic [ADDR_W-1:0] rg_wrt_addr,
    output logic [DATA_W-1:0] rg_wrt_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic              fwd_hit1,
    output logic              fwd_hit2,
    output logic [DATA_W-1:0] fwd_data1,
    output logic [DATA_W-1:0] fwd_data2,
    output logic [15:0]       conflict_cnt
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic              alu_gnt;
    logic              ld_gnt;
    logic              xfer;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req_alu (alu_valid),
        .req_ld  (ld_valid),
        .gnt_alu (alu_gnt),
        .gnt_ld  (ld_gnt)
    );

    assign alu_ready = alu_gnt;
    assign ld_ready  = ld_gnt;
    assign xfer      = alu_gnt | ld_gnt;

    // Select the winning source's address and data.
    always_comb begin
        win_addr = alu_addr;
        win_data = alu_data;
        if (ld_gnt) begin
            win_addr = ld_addr;
            win_data = ld_data;
        end
    end

    // Output stage drains every cycle; x0 targets never raise the enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rg_wrt_en   <= 1'b0;
            rg_wrt_addr <= '0;
            rg_wrt_data <= '0;
        end else begin
            rg_wrt_en <= xfer && (win_addr != ZERO_ADDR);
            if (xfer) begin
                rg_wrt_addr <= win_addr;
                rg_wrt_data <= win_data;
            end
        end
    end

    // Saturating count of cycles with both sources requesting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conflict_cnt <= '0;
        end else if (alu_valid && ld_valid && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

`ifdef RF_WB_FWD_EN
    // Expose the staged write to readers of the same non-zero register.
    always_comb begin
        fwd_hit1  = rg_wrt_en && (rg_wrt_addr == rd_addr1)
                    && (rd_addr1 != ZERO_ADDR);
        fwd_hit2  = rg_wrt_en && (rg_wrt_addr == rd_addr2)
                    && (rd_addr2 != ZERO_ADDR);
        fwd_data1 = fwd_hit1 ? rg_wrt_data : '0;
        fwd_data2 = fwd_hit2 ? rg_wrt_data : '0;
    end
`else
    logic unused_rd_addr;

    assign unused_rd_addr = ^{rd_addr1, rd_addr2};
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed cases plus random
// traffic compared against a behavioural model of the arbitration rules.
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        rg_wrt_en;
    logic [4:0]  rg_wrt_addr;
    logic [31:0] rg_wrt_data;
    logic [4:0]  rd_addr1, rd_addr2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
    logic [15:0] conflict_cnt;

    rf_wb_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_addr     (alu_addr),
        .alu_data     (alu_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .ld_addr      (ld_addr),
        .ld_data      (ld_data),
        .rg_wrt_en    (rg_wrt_en),
        .rg_wrt_addr  (rg_wrt_addr),
        .rg_wrt_data  (rg_wrt_data),
        .rd_addr1     (rd_addr1),
        .rd_addr2     (rd_addr2),
        .fwd_hit1     (fwd_hit1),
        .fwd_hit2     (fwd_hit2),
        .fwd_data1    (fwd_data1),
        .fwd_data2    (fwd_data2),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: who won most recently (0 = ALU, 1 = LD),
    // the expected output stage, and the conflict count.
    int          m_last;
    logic        m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_known;
    int          m_cnt;
    bit          acc_a, acc_l;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_last  = 1;
        m_en    = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        m_known = 1'b1;
        m_cnt   = 0;
        acc_a   = 1'b0;
        acc_l   = 1'b0;
    endtask

    // One clock: drive at negedge, check ready, then check the stage.
    task automatic step(input logic av, input logic [4:0] aa,
                        input logic [31:0] ad, input logic lv,
                        input logic [4:0] la, input logic [31:0] ldd,
                        input logic [4:0] r1, input logic [4:0] r2);
        bit ga, gl, h1, h2;
        logic [4:0]  wa;
        logic [31:0] wd;
        @(negedge clk);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        ld_valid  = lv; ld_addr  = la; ld_data  = ldd;
        rd_addr1  = r1; rd_addr2 = r2;
        #1;
        if (av && lv) begin
            ga = (m_last == 1);
            gl = !ga;
        end else begin
            ga = av;
            gl = lv;
        end
        check("alu_ready", 32'(alu_ready), 32'(ga));
        check("ld_ready", 32'(ld_ready), 32'(gl));
        if (av && lv && m_cnt < 65535) m_cnt++;
        if (ga || gl) begin
            m_last = ga ? 0 : 1;
            wa = ga ? aa : la;
            wd = ga ? ad : ldd;
            m_en = (wa != 0);
            if (m_en) begin
                m_addr  = wa;
                m_data  = wd;
                m_known = 1'b1;
            end else begin
                m_known = 1'b0;
            end
        end else begin
            m_en = 1'b0;
        end
        acc_a = ga;
        acc_l = gl;
        @(posedge clk);
        #1;
        check("wrt_en", 32'(rg_wrt_en), 32'(m_en));
        if (m_known) begin
            check("wrt_addr", 32'(rg_wrt_addr), 32'(m_addr));
            check("wrt_data", rg_wrt_data, m_data);
        end
        check("conflict_cnt", 32'(conflict_cnt), 32'(m_cnt));
`ifdef RF_WB_FWD_EN
        h1 = m_en && (m_addr == r1) && (r1 != 0);
        h2 = m_en && (m_addr == r2) && (r2 != 0);
`else
        h1 = 1'b0;
        h2 = 1'b0;
`endif
        check("fwd_hit1", 32'(fwd_hit1), 32'(h1));
        check("fwd_hit2", 32'(fwd_hit2), 32'(h2));
        check("fwd_data1", fwd_data1, h1 ? m_data : 32'h0);
        check("fwd_data2", fwd_data2, h2 ? m_data : 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, 32'(rg_wrt_en), 32'h0);
        check({tag, "_addr"}, 32'(rg_wrt_addr), 32'h0);
        check({tag, "_data"}, rg_wrt_data, 32'h0);
        check({tag, "_cnt"}, 32'(conflict_cnt), 32'h0);
        check({tag, "_alu_rdy"}, 32'(alu_ready), 32'h0);
        check({tag, "_ld_rdy"}, 32'(ld_ready), 32'h0);
        check({tag, "_hit1"}, 32'(fwd_hit1), 32'h0);
        check({tag, "_hit2"}, 32'(fwd_hit2), 32'h0);
    endtask

    initial begin
        logic        av, lv;
        logic [4:0]  aa, la;
        logic [31:0] ad, ldd;

        reset_n   = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_addr  = '0; ld_data  = '0;
        rd_addr1  = '0;   rd_addr2 = '0;
        model_reset();

        // Reset held with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            alu_valid = 1'($urandom); alu_addr = 5'($urandom);
            alu_data  = $urandom;
            ld_valid  = 1'($urandom); ld_addr  = 5'($urandom);
            ld_data   = $urandom;
            rd_addr1  = 5'($urandom); rd_addr2 = 5'($urandom);
            #1;
            check_reset_outputs("rst");
        end
        @(negedge clk);
        alu_valid = 1'b0;
        ld_valid  = 1'b0;
        reset_n   = 1'b1;

        // Idle after release.
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Sustained contention: ALU, LD, ALU, LD.
        for (int i = 0; i < 4; i++) begin
            step(1, 5'd1, 32'h1000 + i, 1, 5'd2, 32'h2000 + i, 0, 0);
            check("contend_addr", 32'(rg_wrt_addr), (i % 2 == 0) ? 1 : 2);
        end
        check("contend_cnt4", 32'(conflict_cnt), 32'd4);

        // Single ALU source.
        step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        check("single_en", 32'(rg_wrt_en), 32'h1);
        check("single_addr", 32'(rg_wrt_addr), 32'd5);
        check("single_data", rg_wrt_data, 32'hDEADBEEF);

        // Load to x0: accepted, no write.
        step(0, 0, 0, 1, 5'd0, 32'h1, 0, 0);
        check("x0_en", 32'(rg_wrt_en), 32'h0);

        // Pointer advanced on the x0 transfer, so the ALU wins now.
        step(1, 5'd10, 32'hA0A0A0A0, 1, 5'd11, 32'hB0B0B0B0, 0, 0);
        check("after_x0_addr", 32'(rg_wrt_addr), 32'd10);

        // Staged write visible to matching readers.
        step(1, 5'd7, 32'hCAFE0001, 0, 0, 0, 5'd7, 5'd3);
`ifdef RF_WB_FWD_EN
        check("fwd_hit1_dir", 32'(fwd_hit1), 32'h1);
        check("fwd_data1_dir", fwd_data1, 32'hCAFE0001);
`else
        check("fwd_hit1_off", 32'(fwd_hit1), 32'h0);
        check("fwd_data1_off", fwd_data1, 32'h0);
`endif
        check("fwd_hit2_dir", 32'(fwd_hit2), 32'h0);

        // Mid-operation reset drops the staged ALU write.
        step(1, 5'd9, 32'h99999999, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        #2;
        check("midrst_en", 32'(rg_wrt_en), 32'h0);
        check("midrst_cnt", 32'(conflict_cnt), 32'h0);
        reset_n = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 5'd12, 32'h12121212, 1, 5'd13, 32'h13131313, 0, 0);
        check("midrst_ptr", 32'(rg_wrt_addr), 32'd12);

        // Random traffic; a refused request is held unchanged.
        av = 0; aa = 0; ad = 0;
        lv = 0; la = 0; ldd = 0;
        acc_a = 1'b0; acc_l = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!(av && !acc_a)) begin
                av = ($urandom_range(0, 99) < 60);
                aa = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
                ad = $urandom;
            end
            if (!(lv && !acc_l)) begin
                lv = ($urandom_range(0, 99) < 60);
                la = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
                ldd = $urandom;
            end
            step(av, aa, ad, lv, la, ldd,
                 5'($urandom_range(0, 3)), 5'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
